// File: rtl/traffic_sched.sv
// traffic_sched -- two-road traffic light scheduler with all-red clearance,
// emergency hold and optional pedestrian-request green shortening.
//
// Optional feature macro: TRAFFIC_SCHED_PED_EN
//   defined   : ped_s/ped_w latch request flags; a pending request on the
//               opposing road caps the remaining green at T_CAP.
//   undefined : ped_s/ped_w are ignored and timing is fixed.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-low reset
//   tick     in   timebase strobe; timers move only on edges with tick=1
//   ped_s    in   request for south-road green
//   ped_w    in   request for west-road green
//   emerg    in   emergency hold (level)
//   light_s  out  south lamps, one-hot {green, yellow, red}
//   light_w  out  west lamps, same encoding
//   phase    out  current state code
//   remain   out  ticks left in the current state, minus one
module traffic_sched #(
    parameter int unsigned T_GREEN  = 20,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_CAP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_s,
    input  logic       ped_w,
    input  logic       emerg,
    output logic [2:0] light_s,
    output logic [2:0] light_w,
    output logic [2:0] phase,
    output logic [7:0] remain
);

    typedef enum logic [2:0] {
        S_GRN = 3'd0,
        S_YEL = 3'd1,
        RED1  = 3'd2,
        W_GRN = 3'd3,
        W_YEL = 3'd4,
        RED2  = 3'd5,
        HOLD  = 3'd6
    } state_t;

    // Reload values: a state lasting N ticks starts at N-1.
    localparam logic [7:0] L_GREEN  = 8'(T_GREEN - 1);
    localparam logic [7:0] L_YELLOW = 8'(T_YELLOW - 1);
    localparam logic [7:0] L_ALLRED = 8'(T_ALLRED - 1);
    localparam logic [7:0] L_CAP    = 8'(T_CAP);

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    state_t     r_state;
    state_t     w_state_d;
    logic [7:0] r_remain;
    logic [7:0] w_remain_d;
    logic [2:0] r_light_s;
    logic [2:0] r_light_w;
    logic [2:0] w_light_s_d;
    logic [2:0] w_light_w_d;
    logic       w_cap;

    // ------------------------------------------------------------------
    // Pedestrian request flags
    // ------------------------------------------------------------------
`ifdef TRAFFIC_SCHED_PED_EN
    logic r_req_s;
    logic r_req_w;
    logic w_req_s_d;
    logic w_req_w_d;

    always_comb begin
        w_req_s_d = r_req_s;
        w_req_w_d = r_req_w;
        // A request for the road already green is meaningless.
        if (ped_s && (r_state != S_GRN)) begin
            w_req_s_d = 1'b1;
        end
        if (ped_w && (r_state != W_GRN)) begin
            w_req_w_d = 1'b1;
        end
        // Served on green entry; clearing overrides a same-edge set.
        if ((w_state_d == S_GRN) && (r_state != S_GRN)) begin
            w_req_s_d = 1'b0;
        end
        if ((w_state_d == W_GRN) && (r_state != W_GRN)) begin
            w_req_w_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_s <= 1'b0;
            r_req_w <= 1'b0;
        end else begin
            r_req_s <= w_req_s_d;
            r_req_w <= w_req_w_d;
        end
    end

    assign w_cap = ((r_state == S_GRN) && r_req_w) || ((r_state == W_GRN) && r_req_s);
`else
    logic w_unused_ped;
    assign w_unused_ped = ped_s ^ ped_w;
    assign w_cap        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / countdown
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state;
        w_remain_d = r_remain;
        if (emerg) begin
            w_state_d  = HOLD;
            w_remain_d = 8'd0;
        end else if (r_state == HOLD) begin
            // Resume through all-red so service restarts with the south road.
            w_state_d  = RED2;
            w_remain_d = L_ALLRED;
        end else if (tick) begin
            if (r_remain == 8'd0) begin
                case (r_state)
                    S_GRN: begin
                        w_state_d  = S_YEL;
                        w_remain_d = L_YELLOW;
                    end
                    S_YEL: begin
                        w_state_d  = RED1;
                        w_remain_d = L_ALLRED;
                    end
                    RED1: begin
                        w_state_d  = W_GRN;
                        w_remain_d = L_GREEN;
                    end
                    W_GRN: begin
                        w_state_d  = W_YEL;
                        w_remain_d = L_YELLOW;
                    end
                    W_YEL: begin
                        w_state_d  = RED2;
                        w_remain_d = L_ALLRED;
                    end
                    default: begin
                        w_state_d  = S_GRN;
                        w_remain_d = L_GREEN;
                    end
                endcase
            end else if (w_cap && (r_remain > L_CAP)) begin
                w_remain_d = L_CAP;
            end else begin
                w_remain_d = r_remain - 8'd1;
            end
        end
    end

    // Lamps are decoded from the next state so the registered lamps always
    // match the registered state; only one road can ever be non-red.
    always_comb begin
        w_light_s_d = LAMP_R;
        w_light_w_d = LAMP_R;
        case (w_state_d)
            S_GRN:   w_light_s_d = LAMP_G;
            S_YEL:   w_light_s_d = LAMP_Y;
            W_GRN:   w_light_w_d = LAMP_G;
            W_YEL:   w_light_w_d = LAMP_Y;
            default: begin
                w_light_s_d = LAMP_R;
                w_light_w_d = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_GRN;
            r_remain  <= L_GREEN;
            r_light_s <= LAMP_G;
            r_light_w <= LAMP_R;
        end else begin
            r_state   <= w_state_d;
            r_remain  <= w_remain_d;
            r_light_s <= w_light_s_d;
            r_light_w <= w_light_w_d;
        end
    end

    assign light_s = r_light_s;
    assign light_w = r_light_w;
    assign phase   = r_state;
    assign remain  = r_remain;

endmodule

// File: tb/tb_traffic_sched.sv
module tb_traffic_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ped_s;
    logic       ped_w;
    logic       emerg;
    logic [2:0] light_s;
    logic [2:0] light_w;
    logic [2:0] phase;
    logic [7:0] remain;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_sched dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .ped_s   (ped_s),
        .ped_w   (ped_w),
        .emerg   (emerg),
        .light_s (light_s),
        .light_w (light_w),
        .phase   (phase),
        .remain  (remain)
    );

    typedef struct {
        logic       tk;
        logic       ps;
        logic       pw;
        logic       em;
        logic [2:0] ph;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [2:0] exp_ls(input logic [2:0] ph);
        if (ph == 3'd0) return 3'b100;
        if (ph == 3'd1) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [2:0] exp_lw(input logic [2:0] ph);
        if (ph == 3'd3) return 3'b100;
        if (ph == 3'd4) return 3'b010;
        return 3'b001;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [2:0] ph, input logic [7:0] rem);
        cmp({name, ".phase"}, 32'(phase), 32'(ph));
        cmp({name, ".remain"}, 32'(remain), 32'(rem));
        cmp({name, ".light_s"}, 32'(light_s), 32'(exp_ls(ph)));
        cmp({name, ".light_w"}, 32'(light_w), 32'(exp_lw(ph)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick every 4 clocks; ends 1 time unit after an edge.
    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic reset_dut();
        tick  = 1'b0;
        ped_s = 1'b0;
        ped_w = 1'b0;
        emerg = 1'b0;
        rst   = 1'b0;
        step();
        chk("reset", 3'd0, 8'd19);
        rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dur [6];
        int cnt;
        int exp_cnt;
        dur = '{20, 3, 2, 20, 3, 2};

        // {tick, ped_s, ped_w, emerg, phase, remain} after one clock
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd19};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd18};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd18};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd17};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 8'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 8'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'd1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd19};

        reset_dut();
        for (int i = 0; i < 9; i++) begin
            tick  = vecs[i].tk;
            ped_s = vecs[i].ps;
            ped_w = vecs[i].pw;
            emerg = vecs[i].em;
            step();
            chk($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rem);
        end
        tick  = 1'b0;
        ped_s = 1'b0;
        emerg = 1'b0;

        // Full 50-tick cycle with no requests.
        reset_dut();
        for (int p = 0; p < 6; p++) begin
            for (int r = dur[p] - 1; r >= 0; r--) begin
                chk($sformatf("cycle_p%0d_r%0d", p, r), 3'(p), 8'(r));
                do_tick();
            end
        end
        chk("cycle_wrap", 3'd0, 8'd19);

        // West request at S_GRN remain=15.
        reset_dut();
        ticks(4);
        chk("cap_pre", 3'd0, 8'd15);
        ped_w = 1'b1;
        step();
        ped_w = 1'b0;
        chk("cap_hold", 3'd0, 8'd15);
        do_tick();
`ifdef TRAFFIC_SCHED_PED_EN
        chk("cap_load", 3'd0, 8'd4);
        exp_cnt = 5;
`else
        chk("cap_load", 3'd0, 8'd14);
        exp_cnt = 15;
`endif
        cnt = 0;
        while (phase == 3'd0 && cnt < 40) begin
            do_tick();
            cnt++;
        end
        cmp("cap_ticks_to_yel", 32'(cnt), 32'(exp_cnt));
        chk("cap_yel", 3'd1, 8'd2);
        ticks(5);
        chk("cap_wgrn", 3'd3, 8'd19);
        do_tick();
        chk("cap_wgrn_nocap", 3'd3, 8'd18);
        ticks(24);
        chk("cap_back_sgrn", 3'd0, 8'd19);
        do_tick();
        chk("cap_flag_cleared", 3'd0, 8'd18);

        // West request at remain=3 gives no shortening.
        reset_dut();
        ticks(16);
        chk("nocap_pre", 3'd0, 8'd3);
        ped_w = 1'b1;
        step();
        ped_w = 1'b0;
        do_tick();
        chk("nocap_count", 3'd0, 8'd2);

        // South request during S_GRN is ignored.
        reset_dut();
        ped_s = 1'b1;
        ticks(3);
        ped_s = 1'b0;
        ticks(22);
        chk("peds_wgrn", 3'd3, 8'd19);
        do_tick();
        chk("peds_ignored", 3'd3, 8'd18);

        // Emergency in W_GRN remain=10.
        reset_dut();
        ticks(34);
        chk("em_pre", 3'd3, 8'd10);
        emerg = 1'b1;
        step();
        chk("em_hold", 3'd6, 8'd0);
        step();
        step();
        chk("em_hold2", 3'd6, 8'd0);
        emerg = 1'b0;
        step();
        chk("em_red2", 3'd5, 8'd1);
        do_tick();
        chk("em_red2b", 3'd5, 8'd0);
        do_tick();
        chk("em_sgrn", 3'd0, 8'd19);

        // Asynchronous reset mid W_YEL.
        reset_dut();
        ticks(46);
        chk("ar_pre", 3'd4, 8'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_immediate", 3'd0, 8'd19);
        step();
        rst = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ar_first_edge", 3'd0, 8'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
